// File: rtl/instr_mem_loader.sv
// -----------------------------------------------------------------------------
// instr_mem_loader
//   Assembles 32-bit instruction words from a byte stream (MSB first) and
//   writes them into instruction memory at consecutive word addresses starting
//   at 0. A HALT word is written and then ends the load. Words whose opcode is
//   outside the decoder's supported set are not written and stop the load with
//   an error. A supported word landing in the last memory slot is written, but
//   the load then stops with a memory-full error because HALT has nowhere to go.
//
// Ports
//   i_clk          clock, rising edge
//   i_reset_n      asynchronous reset, active low
//   i_start        begin a load (honoured in IDLE, DONE and ERROR only)
//   i_byte         stream byte
//   i_byte_valid   i_byte is valid this cycle
//   o_byte_ready   loader accepts a byte this cycle (high only in RECV)
//   o_imem_we      instruction memory write enable, one-cycle pulse
//   o_imem_addr    instruction memory word address
//   o_imem_data    word to write (meaningful while o_imem_we is high)
//   o_busy         high in RECV and WRITE
//   o_done         high in DONE
//   o_err          00 none, 01 illegal opcode, 10 memory full
//   o_word_count   words written in the current load, HALT included
// -----------------------------------------------------------------------------
module instr_mem_loader #(
  parameter int                    NBITS_DATA = 32,
  parameter int                    NBITS_ADDR = 8,
  parameter logic [NBITS_DATA-1:0] HALT_WORD  = 32'hFFFF_FFFF
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_start,
  input  logic [7:0]            i_byte,
  input  logic                  i_byte_valid,
  output logic                  o_byte_ready,
  output logic                  o_imem_we,
  output logic [NBITS_ADDR-1:0] o_imem_addr,
  output logic [NBITS_DATA-1:0] o_imem_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [1:0]            o_err,
  output logic [NBITS_ADDR:0]   o_word_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } loaderStateT;

  localparam logic [1:0]            ERR_NONE    = 2'b00;
  localparam logic [1:0]            ERR_ILLEGAL = 2'b01;
  localparam logic [1:0]            ERR_FULL    = 2'b10;
  localparam logic [NBITS_ADDR-1:0] ADDR_ZERO   = {NBITS_ADDR{1'b0}};
  localparam logic [NBITS_ADDR-1:0] ADDR_ONE    = {{(NBITS_ADDR-1){1'b0}}, 1'b1};
  localparam logic [NBITS_ADDR-1:0] ADDR_MAX    = {NBITS_ADDR{1'b1}};
  localparam logic [NBITS_ADDR:0]   COUNT_ZERO  = {(NBITS_ADDR+1){1'b0}};
  localparam logic [NBITS_ADDR:0]   COUNT_ONE   = {{NBITS_ADDR{1'b0}}, 1'b1};
  localparam logic [NBITS_DATA-1:0] WORD_ZERO   = {NBITS_DATA{1'b0}};

  // Opcodes the downstream decoder understands: R-type, addi, lw, sw, beq, j.
  function automatic logic isSupportedOpcode(input logic [5:0] opcode);
    logic supported;
    case (opcode)
      6'b000000: supported = 1'b1;
      6'b001000: supported = 1'b1;
      6'b100011: supported = 1'b1;
      6'b101011: supported = 1'b1;
      6'b000100: supported = 1'b1;
      6'b000010: supported = 1'b1;
      default:   supported = 1'b0;
    endcase
    return supported;
  endfunction

  // A word is written to memory if it is HALT or carries a supported opcode.
  function automatic logic isWritable(input logic [NBITS_DATA-1:0] word);
    return (word == HALT_WORD) || isSupportedOpcode(word[NBITS_DATA-1 -: 6]);
  endfunction

  loaderStateT           stateR;
  logic [1:0]            byteCntR;
  logic [NBITS_DATA-1:0] shiftR;
  logic [NBITS_DATA-1:0] nextWordS;

  // Word as it will look once the byte currently on i_byte is shifted in.
  assign nextWordS   = {shiftR[NBITS_DATA-9:0], i_byte};
  // The shift register holds the complete word throughout WRITE.
  assign o_imem_data = shiftR;

  // Loader FSM: byte assembly, word classification and all registered outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      stateR       <= IDLE;
      byteCntR     <= 2'd0;
      shiftR       <= WORD_ZERO;
      o_byte_ready <= 1'b0;
      o_imem_we    <= 1'b0;
      o_imem_addr  <= ADDR_ZERO;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_err        <= ERR_NONE;
      o_word_count <= COUNT_ZERO;
    end else begin
      // The write strobe is a single-cycle pulse unless re-armed below.
      o_imem_we <= 1'b0;
      case (stateR)
        IDLE, DONE, ERROR: begin
          if (i_start) begin
            stateR       <= RECV;
            byteCntR     <= 2'd0;
            shiftR       <= WORD_ZERO;
            o_byte_ready <= 1'b1;
            o_imem_addr  <= ADDR_ZERO;
            o_busy       <= 1'b1;
            o_done       <= 1'b0;
            o_err        <= ERR_NONE;
            o_word_count <= COUNT_ZERO;
          end else begin
            stateR <= stateR;
          end
        end

        RECV: begin
          if (i_byte_valid && o_byte_ready) begin
            shiftR <= nextWordS;
            if (byteCntR == 2'd3) begin
              // Fourth byte: the strobe is raised now so that it is high for
              // exactly the WRITE cycle, alongside the completed word.
              stateR       <= WRITE;
              byteCntR     <= 2'd0;
              o_byte_ready <= 1'b0;
              o_imem_we    <= isWritable(nextWordS);
            end else begin
              byteCntR <= byteCntR + 2'd1;
            end
          end else begin
            stateR <= RECV;
          end
        end

        WRITE: begin
          if (shiftR == HALT_WORD) begin
            stateR       <= DONE;
            o_busy       <= 1'b0;
            o_done       <= 1'b1;
            o_word_count <= o_word_count + COUNT_ONE;
          end else if (isSupportedOpcode(shiftR[NBITS_DATA-1 -: 6])) begin
            o_word_count <= o_word_count + COUNT_ONE;
            if (o_imem_addr == ADDR_MAX) begin
              // Last slot consumed by a non-HALT word: no room left for HALT.
              stateR <= ERROR;
              o_busy <= 1'b0;
              o_err  <= ERR_FULL;
            end else begin
              stateR       <= RECV;
              o_byte_ready <= 1'b1;
              o_imem_addr  <= o_imem_addr + ADDR_ONE;
            end
          end else begin
            // Rejected word: address keeps pointing at the offending slot.
            stateR <= ERROR;
            o_busy <= 1'b0;
            o_err  <= ERR_ILLEGAL;
          end
        end

        default: begin
          stateR       <= IDLE;
          byteCntR     <= 2'd0;
          o_byte_ready <= 1'b0;
          o_busy       <= 1'b0;
          o_done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_mem_loader
//   Directed bench for instr_mem_loader. Two instances: dut0 with the default
//   256-word memory and dut1 with a 4-word memory for the memory-full case.
//   Expected memory writes are queued when stimulus is issued; monitor blocks
//   pop and compare on every write strobe.
// -----------------------------------------------------------------------------
module tb_instr_mem_loader;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wrT;

  logic        clk;
  logic        rstN0, rstN1;
  logic        start0, start1;
  logic [7:0]  byte0, byte1;
  logic        bv0, bv1;
  logic        rdy0, rdy1;
  logic        we0, we1;
  logic [7:0]  addr0;
  logic [1:0]  addr1;
  logic [31:0] data0, data1;
  logic        busy0, busy1;
  logic        done0, done1;
  logic [1:0]  err0, err1;
  logic [8:0]  wc0;
  logic [2:0]  wc1;

  int tests    = 0;
  int failures = 0;

  wrT exp0[$];
  wrT exp1[$];
  wrT e0, e1;

  instr_mem_loader #(.NBITS_DATA(32), .NBITS_ADDR(8)) dut0 (
    .i_clk(clk), .i_reset_n(rstN0), .i_start(start0), .i_byte(byte0),
    .i_byte_valid(bv0), .o_byte_ready(rdy0), .o_imem_we(we0),
    .o_imem_addr(addr0), .o_imem_data(data0), .o_busy(busy0),
    .o_done(done0), .o_err(err0), .o_word_count(wc0)
  );

  instr_mem_loader #(.NBITS_DATA(32), .NBITS_ADDR(2)) dut1 (
    .i_clk(clk), .i_reset_n(rstN1), .i_start(start1), .i_byte(byte1),
    .i_byte_valid(bv1), .o_byte_ready(rdy1), .o_imem_we(we1),
    .o_imem_addr(addr1), .o_imem_data(data1), .o_busy(busy1),
    .o_done(done1), .o_err(err1), .o_word_count(wc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor for dut0.
  always @(negedge clk) begin
    if (we0 === 1'b1) begin
      if (exp0.size() == 0) begin
        tests++;
        failures++;
        $display("FAIL dut0_unexpected_we: addr 0x%0h data 0x%0h, expected no write", addr0, data0);
      end else begin
        e0 = exp0.pop_front();
        chk("dut0_wr_addr", {56'd0, addr0}, {56'd0, e0.addr});
        chk("dut0_wr_data", {32'd0, data0}, {32'd0, e0.data});
      end
    end
  end

  // Scoreboard monitor for dut1.
  always @(negedge clk) begin
    if (we1 === 1'b1) begin
      if (exp1.size() == 0) begin
        tests++;
        failures++;
        $display("FAIL dut1_unexpected_we: addr 0x%0h data 0x%0h, expected no write", addr1, data1);
      end else begin
        e1 = exp1.pop_front();
        chk("dut1_wr_addr", {62'd0, addr1}, {56'd0, e1.addr});
        chk("dut1_wr_data", {32'd0, data1}, {32'd0, e1.data});
      end
    end
  end

  task automatic expectWr(input int sel, input logic [7:0] a, input logic [31:0] d);
    wrT w;
    w.addr = a;
    w.data = d;
    if (sel == 0) exp0.push_back(w);
    else          exp1.push_back(w);
  endtask

  // Present one byte after 'gap' idle cycles and hold it until accepted.
  task automatic sendByte(input int sel, input logic [7:0] b, input int gap);
    bit got;
    got = 1'b0;
    repeat (gap) @(posedge clk);
    #1;
    if (sel == 0) begin byte0 = b; bv0 = 1'b1; end
    else          begin byte1 = b; bv1 = 1'b1; end
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      if (((sel == 0) ? rdy0 : rdy1) === 1'b1) begin
        @(posedge clk);
        got = 1'b1;
      end
    end
    #1;
    if (sel == 0) bv0 = 1'b0;
    else          bv1 = 1'b0;
    chk("byte_accept", {63'd0, got}, 64'd1);
  endtask

  task automatic sendWord(input int sel, input logic [31:0] w, input bit randGap);
    for (int i = 0; i < 4; i++) begin
      sendByte(sel, w[31-8*i -: 8], randGap ? int'($urandom_range(7, 1)) : 0);
    end
  endtask

  task automatic pulseStart(input int sel);
    #1;
    if (sel == 0) start0 = 1'b1;
    else          start1 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic resetDut0();
    #1 rstN0 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstN0 = 1'b1;
  endtask

  // Hard time limit so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstN0 = 1'b0; rstN1 = 1'b0;
    start0 = 1'b0; start1 = 1'b0;
    byte0 = 8'h00; byte1 = 8'h00;
    bv0 = 1'b0; bv1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    chk("rst_ready", {63'd0, rdy0}, 64'd0);
    chk("rst_we",    {63'd0, we0},  64'd0);
    chk("rst_addr",  {56'd0, addr0}, 64'd0);
    chk("rst_data",  {32'd0, data0}, 64'd0);
    chk("rst_busy",  {63'd0, busy0}, 64'd0);
    chk("rst_done",  {63'd0, done0}, 64'd0);
    chk("rst_err",   {62'd0, err0},  64'd0);
    chk("rst_wc",    {55'd0, wc0},   64'd0);
    rstN0 = 1'b1; rstN1 = 1'b1;
    @(posedge clk);

    // Test 1: single word, write latency
    pulseStart(0);
    chk("t1_ready_after_start", {63'd0, rdy0}, 64'd1);
    chk("t1_busy_after_start",  {63'd0, busy0}, 64'd1);
    expectWr(0, 8'd0, 32'h2001_0005);
    sendWord(0, 32'h2001_0005, 1'b0);
    chk("t1_we_after_4th", {63'd0, we0}, 64'd1);
    chk("t1_ready_in_write", {63'd0, rdy0}, 64'd0);
    @(posedge clk); #1;
    chk("t1_we_pulse_end", {63'd0, we0}, 64'd0);
    chk("t1_wc", {55'd0, wc0}, 64'd1);
    chk("t1_ready_recv", {63'd0, rdy0}, 64'd1);
    chk("t1_busy_recv", {63'd0, busy0}, 64'd1);

    // Test 2: program with HALT
    resetDut0();
    pulseStart(0);
    expectWr(0, 8'd0, 32'h8C22_0004);
    expectWr(0, 8'd1, 32'h0043_0820);
    expectWr(0, 8'd2, HALT);
    sendWord(0, 32'h8C22_0004, 1'b0);
    sendWord(0, 32'h0043_0820, 1'b0);
    sendWord(0, HALT, 1'b0);
    @(posedge clk); #1;
    chk("t2_done", {63'd0, done0}, 64'd1);
    chk("t2_busy", {63'd0, busy0}, 64'd0);
    chk("t2_wc",   {55'd0, wc0},   64'd3);
    chk("t2_err",  {62'd0, err0},  64'd0);
    chk("t2_addr", {56'd0, addr0}, 64'd2);

    // Bytes offered outside RECV are not consumed
    #1 byte0 = 8'hAA; bv0 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_valid_ready", {63'd0, rdy0}, 64'd0);
    bv0 = 1'b0;

    // Test 3: illegal opcode, then restart
    pulseStart(0);
    chk("t3_done_cleared", {63'd0, done0}, 64'd0);
    chk("t3_wc_cleared",   {55'd0, wc0},   64'd0);
    sendWord(0, 32'h0C00_0010, 1'b0);
    chk("t3_no_we", {63'd0, we0}, 64'd0);
    @(posedge clk); #1;
    chk("t3_err",  {62'd0, err0},  64'd1);
    chk("t3_addr", {56'd0, addr0}, 64'd0);
    chk("t3_busy", {63'd0, busy0}, 64'd0);
    chk("t3_ready", {63'd0, rdy0}, 64'd0);
    repeat (2) @(posedge clk); #1;
    chk("t3_err_held", {62'd0, err0}, 64'd1);
    pulseStart(0);
    chk("t3_err_cleared", {62'd0, err0}, 64'd0);
    chk("t3_addr_restart", {56'd0, addr0}, 64'd0);
    expectWr(0, 8'd0, 32'h8C22_0004);
    expectWr(0, 8'd1, HALT);
    sendWord(0, 32'h8C22_0004, 1'b0);
    sendWord(0, HALT, 1'b0);
    @(posedge clk); #1;
    chk("t3_done", {63'd0, done0}, 64'd1);
    chk("t3_wc",   {55'd0, wc0},   64'd2);

    // Test 4: memory full on the 4-word instance
    pulseStart(1);
    for (int i = 0; i < 4; i++) expectWr(1, 8'(i), 32'h2000_0000);
    for (int i = 0; i < 4; i++) sendWord(1, 32'h2000_0000, 1'b0);
    @(posedge clk); #1;
    chk("t4_err",  {62'd0, err1},  64'd2);
    chk("t4_done", {63'd0, done1}, 64'd0);
    chk("t4_wc",   {61'd0, wc1},   64'd4);
    chk("t4_addr", {62'd0, addr1}, 64'd3);
    chk("t4_busy", {63'd0, busy1}, 64'd0);

    // Test 5: random gaps; start mid-word is ignored
    pulseStart(0);
    expectWr(0, 8'd0, 32'h2001_0005);
    expectWr(0, 8'd1, 32'h8C22_0004);
    expectWr(0, 8'd2, 32'hAC43_0008);
    expectWr(0, 8'd3, 32'h1000_FFFF);
    expectWr(0, 8'd4, 32'h0800_0004);
    expectWr(0, 8'd5, HALT);
    sendByte(0, 8'h20, 3);
    sendByte(0, 8'h01, 1);
    pulseStart(0);
    sendByte(0, 8'h00, 7);
    sendByte(0, 8'h05, 2);
    sendWord(0, 32'h8C22_0004, 1'b1);
    sendWord(0, 32'hAC43_0008, 1'b1);
    sendWord(0, 32'h1000_FFFF, 1'b1);
    sendWord(0, 32'h0800_0004, 1'b1);
    sendWord(0, HALT, 1'b1);
    @(posedge clk); #1;
    chk("t5_done", {63'd0, done0}, 64'd1);
    chk("t5_wc",   {55'd0, wc0},   64'd6);
    chk("t5_err",  {62'd0, err0},  64'd0);

    // Test 6: reset mid-word, then restart
    pulseStart(0);
    sendByte(0, 8'h10, 0);
    sendByte(0, 8'h22, 0);
    #2 rstN0 = 1'b0;
    #1;
    chk("t6_rst_ready", {63'd0, rdy0},  64'd0);
    chk("t6_rst_busy",  {63'd0, busy0}, 64'd0);
    chk("t6_rst_data",  {32'd0, data0}, 64'd0);
    chk("t6_rst_addr",  {56'd0, addr0}, 64'd0);
    chk("t6_rst_done",  {63'd0, done0}, 64'd0);
    @(posedge clk);
    #1 rstN0 = 1'b1;
    @(posedge clk);
    pulseStart(0);
    expectWr(0, 8'd0, 32'h1022_0003);
    expectWr(0, 8'd1, HALT);
    sendWord(0, 32'h1022_0003, 1'b0);
    sendWord(0, HALT, 1'b0);
    @(posedge clk); #1;
    chk("t6_done", {63'd0, done0}, 64'd1);
    chk("t6_wc",   {55'd0, wc0},   64'd2);

    repeat (4) @(posedge clk);
    chk("dut0_all_writes_seen", 64'(exp0.size()), 64'd0);
    chk("dut1_all_writes_seen", 64'(exp1.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
